// File: rtl/ram_pkg.sv
// Shared constants and types for the FMI RAM and its access arbiter.
package ram_pkg;

    // FMI RAM depth in pixels.
    localparam int FMI_N_ELEM = 64;

    // Pixel width in bits.
    localparam int PX_W = 8;

    // Arbiter FSM states. IDLE is the reset state and the only place where
    // DMA and read requests compete; the other two states own the RAM port.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DMA_BURST = 2'd1,
        READ      = 2'd2
    } fmi_arb_state_t;

endpackage : ram_pkg

// File: rtl/fmi_arb_fsm.sv
// Arbitration FSM for the single-port FMI RAM: decides, each cycle, whether
// the DMA writer or the datapath reader owns the port, and counts the read
// grants of the current read run so a waiting DMA burst is not starved.
//
// Handshake: a transfer happens on a rising clock edge where req && gnt.
// Grants are combinational from the registered state and the live requests,
// a grant is never raised without its request, and the two grants are
// mutually exclusive. Requesters must hold req (and addr/data) stable until
// they see gnt.
module fmi_arb_fsm
    import ram_pkg::*;
#(
    parameter int RD_QUOTA = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            dma_req,
    input  logic                            dma_last,
    input  logic                            rd_req,
    output logic                            dma_gnt,
    output logic                            rd_gnt,
    output fmi_arb_state_t                  state_o,
    output logic [$clog2(RD_QUOTA+1)-1:0]   rd_cnt_o
);

    localparam int                CNT_W   = $clog2(RD_QUOTA + 1);
    localparam logic [CNT_W-1:0]  QUOTA   = CNT_W'(RD_QUOTA);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    fmi_arb_state_t    state_q, state_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;

    // High from reset until the first clock edge after reset is released.
    // It keeps the port quiet in that first cycle, so a requester that still
    // holds its request from before the reset cannot slip a write in while
    // the rest of the system is coming out of reset.
    logic              settle_q;
    logic              blocked;

    assign blocked  = reset | settle_q;
    assign state_o  = state_q;
    assign rd_cnt_o = rd_cnt_q;

    // State register, read-run counter and reset-release guard.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            rd_cnt_q <= '0;
            settle_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            rd_cnt_q <= rd_cnt_d;
            settle_q <= 1'b0;
        end
    end

    // Next state, next read count and the two grants.
    always_comb begin
        state_d  = state_q;
        rd_cnt_d = rd_cnt_q;
        dma_gnt  = 1'b0;
        rd_gnt   = 1'b0;

        if (!blocked) begin
            unique case (state_q)
                IDLE: begin
                    rd_cnt_d = '0;
                    if (dma_req) begin
                        // DMA wins ties. A single-word burst (last on the
                        // first word) completes here without leaving IDLE.
                        dma_gnt = 1'b1;
                        state_d = dma_last ? IDLE : DMA_BURST;
                    end else if (rd_req) begin
                        // The read granted here is the first of the run.
                        rd_gnt   = 1'b1;
                        rd_cnt_d = CNT_ONE;
                        state_d  = READ;
                    end
                end

                DMA_BURST: begin
                    // The burst owns the port until its last word is taken;
                    // dma_last without dma_req means nothing.
                    dma_gnt = dma_req;
                    if (dma_req && dma_last) begin
                        state_d  = IDLE;
                        rd_cnt_d = '0;
                    end
                end

                READ: begin
                    if (!rd_req || ((rd_cnt_q >= QUOTA) && dma_req)) begin
                        // Run ends: reader went away, or it used up its
                        // quota while DMA is waiting. IDLE then gives the
                        // port to DMA on the following cycle.
                        state_d  = IDLE;
                        rd_cnt_d = '0;
                    end else begin
                        // Keep streaming one read per cycle; the count
                        // saturates so an uncontested reader never stops.
                        rd_gnt = 1'b1;
                        if (rd_cnt_q < QUOTA) begin
                            rd_cnt_d = rd_cnt_q + CNT_ONE;
                        end
                    end
                end

                default: begin
                    state_d  = IDLE;
                    rd_cnt_d = '0;
                end
            endcase
        end
    end

endmodule : fmi_arb_fsm

// File: rtl/fmi_ram_arbiter.sv
// Shares the single-port FMI RAM between a DMA writer and a datapath reader.
// The FSM sub-module decides ownership; this level steers address/data onto
// the RAM port and aligns read data with the RAM's one-cycle read latency.
//
// Handshake: a DMA word is written on a rising edge where dma_req && dma_gnt;
// a read is issued on a rising edge where rd_req && rd_gnt, and its pixel is
// presented exactly one cycle later with rd_valid high. Requesters hold their
// request, address and data stable until granted.
module fmi_ram_arbiter
    import ram_pkg::fmi_arb_state_t;
#(
    parameter int FMI_N_ELEM = ram_pkg::FMI_N_ELEM,
    parameter int PX_W       = ram_pkg::PX_W,
    parameter int RD_QUOTA   = 8
) (
    input  logic                            clk,
    input  logic                            reset,

    // DMA write port
    input  logic                            dma_req,
    input  logic [$clog2(FMI_N_ELEM)-1:0]   dma_addr,
    input  logic [PX_W-1:0]                 dma_data,
    input  logic                            dma_last,
    output logic                            dma_gnt,

    // Datapath read port
    input  logic                            rd_req,
    input  logic [$clog2(FMI_N_ELEM)-1:0]   rd_addr,
    output logic                            rd_gnt,
    output logic                            rd_valid,
    output logic [PX_W-1:0]                 rd_data,

    // FMI RAM port (1-cycle registered read, write-through)
    output logic [$clog2(FMI_N_ELEM)-1:0]   ram_addr,
    output logic [PX_W-1:0]                 ram_data,
    output logic                            ram_write,
    input  logic [PX_W-1:0]                 ram_res,

    // Debug view of the arbiter state and the current read-run count
    output fmi_arb_state_t                  dbg_state_o,
    output logic [$clog2(RD_QUOTA+1)-1:0]   dbg_rd_cnt_o
);

    localparam int AW = $clog2(FMI_N_ELEM);

    logic [AW-1:0] ram_addr_q;   // last address driven onto the RAM
    logic          rd_valid_q;   // a read was issued on the previous edge

    fmi_arb_fsm #(
        .RD_QUOTA (RD_QUOTA)
    ) u_fsm (
        .clk      (clk),
        .reset    (reset),
        .dma_req  (dma_req),
        .dma_last (dma_last),
        .rd_req   (rd_req),
        .dma_gnt  (dma_gnt),
        .rd_gnt   (rd_gnt),
        .state_o  (dbg_state_o),
        .rd_cnt_o (dbg_rd_cnt_o)
    );

    // RAM port steering. The address holds its previous value on idle cycles
    // so the RAM input does not toggle when nobody is using it; write data is
    // zeroed when not writing to keep it free of stale pixels.
    always_comb begin
        ram_write = dma_gnt;
        ram_addr  = ram_addr_q;
        ram_data  = '0;
        if (dma_gnt) begin
            ram_addr = dma_addr;
            ram_data = dma_data;
        end else if (rd_gnt) begin
            ram_addr = rd_addr;
        end
    end

    // Remember the driven address and track reads in flight through the RAM.
    // Reset clears both, which also drops any read that was still in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_addr_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            ram_addr_q <= ram_addr;
            rd_valid_q <= rd_gnt;
        end
    end

    // The RAM output register already holds the pixel one cycle after the
    // read, so read data is a straight pass-through qualified by rd_valid.
    assign rd_valid = rd_valid_q;
    assign rd_data  = ram_res;

endmodule : fmi_ram_arbiter

// File: tb/tb_fmi_ram_arbiter.sv
// Self-checking bench for fmi_ram_arbiter: directed scenarios followed by a
// randomized run checked against a transaction-level model of the arbiter.
module tb_fmi_ram_arbiter;
    import ram_pkg::*;

    localparam int AW       = $clog2(FMI_N_ELEM);
    localparam int RD_QUOTA = 8;
    localparam int CW       = $clog2(RD_QUOTA + 1);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic                 dma_req, dma_last, dma_gnt;
    logic [AW-1:0]        dma_addr;
    logic [PX_W-1:0]      dma_data;
    logic                 rd_req, rd_gnt, rd_valid;
    logic [AW-1:0]        rd_addr;
    logic [PX_W-1:0]      rd_data;
    logic [AW-1:0]        ram_addr;
    logic [PX_W-1:0]      ram_data;
    logic                 ram_write;
    logic [PX_W-1:0]      ram_res;
    fmi_arb_state_t       dbg_state;
    logic [CW-1:0]        dbg_rd_cnt;

    fmi_ram_arbiter #(
        .FMI_N_ELEM (FMI_N_ELEM),
        .PX_W       (PX_W),
        .RD_QUOTA   (RD_QUOTA)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .dma_req      (dma_req),
        .dma_addr     (dma_addr),
        .dma_data     (dma_data),
        .dma_last     (dma_last),
        .dma_gnt      (dma_gnt),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_gnt       (rd_gnt),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .ram_addr     (ram_addr),
        .ram_data     (ram_data),
        .ram_write    (ram_write),
        .ram_res      (ram_res),
        .dbg_state_o  (dbg_state),
        .dbg_rd_cnt_o (dbg_rd_cnt)
    );

    // ---------------- FMI RAM: 1-cycle registered read, write-through ----------------
    logic [PX_W-1:0] ram_mem [FMI_N_ELEM];
    always @(posedge clk) begin
        if (ram_write) begin
            ram_mem[ram_addr] <= ram_data;
            ram_res           <= ram_data;
        end else begin
            ram_res <= ram_mem[ram_addr];
        end
    end

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [PX_W:0]   exp_q[$];            // {known, pixel} per issued read
    logic [PX_W-1:0] ref_mem [FMI_N_ELEM];
    bit              ref_known [FMI_N_ELEM];

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        dma_req  = 1'b0;
        dma_last = 1'b0;
        rd_req   = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1; dma_req = 1'b1; dma_last = 1'b0; rd_req = 1'b1;
        dma_addr = AW'(9); dma_data = PX_W'(8'h5A); rd_addr = AW'(4);
        @(negedge clk);
        n_cmp++; if (dma_gnt !== 1'b0) begin n_err++; $display("FAIL reset_dma_gnt: got %0b want 0", dma_gnt); end
        n_cmp++; if (rd_gnt !== 1'b0) begin n_err++; $display("FAIL reset_rd_gnt: got %0b want 0", rd_gnt); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid: got %0b want 0", rd_valid); end
        n_cmp++; if (ram_write !== 1'b0) begin n_err++; $display("FAIL reset_ram_write: got %0b want 0", ram_write); end
        n_cmp++; if (ram_addr !== AW'(0)) begin n_err++; $display("FAIL reset_ram_addr: got %0h want 0", ram_addr); end
        n_cmp++; if (ram_data !== PX_W'(0)) begin n_err++; $display("FAIL reset_ram_data: got %0h want 0", ram_data); end
        n_cmp++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE); end
        n_cmp++; if (dbg_rd_cnt !== CW'(0)) begin n_err++; $display("FAIL reset_rd_cnt: got %0d want 0", dbg_rd_cnt); end
        next_cycle();
        reset = 1'b0;  // requests still held high
        @(negedge clk);
        n_cmp++; if (dma_gnt !== 1'b0) begin n_err++; $display("FAIL post_reset_dma_gnt: got %0b want 0", dma_gnt); end
        n_cmp++; if (ram_write !== 1'b0) begin n_err++; $display("FAIL post_reset_ram_write: got %0b want 0", ram_write); end
        n_cmp++; if (rd_gnt !== 1'b0) begin n_err++; $display("FAIL post_reset_rd_gnt: got %0b want 0", rd_gnt); end
        next_cycle();
        drive_idle();
        next_cycle();
    endtask

    task automatic test_burst();
        for (int i = 0; i < 4; i++) begin
            dma_req = 1'b1; dma_addr = AW'(i); dma_data = PX_W'(8'h11 + i);
            dma_last = (i == 3); rd_req = 1'b1; rd_addr = AW'(2);
            @(negedge clk);
            n_cmp++; if (dma_gnt !== 1'b1) begin n_err++; $display("FAIL burst_dma_gnt[%0d]: got %0b want 1", i, dma_gnt); end
            n_cmp++; if (rd_gnt !== 1'b0) begin n_err++; $display("FAIL burst_rd_stall[%0d]: got %0b want 0", i, rd_gnt); end
            n_cmp++; if (ram_write !== 1'b1) begin n_err++; $display("FAIL burst_ram_write[%0d]: got %0b want 1", i, ram_write); end
            n_cmp++; if (ram_addr !== AW'(i)) begin n_err++; $display("FAIL burst_ram_addr[%0d]: got %0h want %0h", i, ram_addr, i); end
            n_cmp++; if (ram_data !== PX_W'(8'h11 + i)) begin n_err++; $display("FAIL burst_ram_data[%0d]: got %0h want %0h", i, ram_data, 8'h11 + i); end
            next_cycle();
        end
        dma_req = 1'b0; dma_last = 1'b0;
        @(negedge clk);
        n_cmp++; if (rd_gnt !== 1'b1) begin n_err++; $display("FAIL burst_then_rd_gnt: got %0b want 1", rd_gnt); end
        n_cmp++; if (ram_write !== 1'b0) begin n_err++; $display("FAIL burst_then_ram_write: got %0b want 0", ram_write); end
        n_cmp++; if (ram_addr !== AW'(2)) begin n_err++; $display("FAIL burst_then_ram_addr: got %0h want 2", ram_addr); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL valid_after_write: got %0b want 0", rd_valid); end
        next_cycle();
        rd_req = 1'b0;
        @(negedge clk);
        n_cmp++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL burst_read_valid: got %0b want 1", rd_valid); end
        n_cmp++; if (rd_data !== PX_W'(8'h13)) begin n_err++; $display("FAIL burst_read_data: got %0h want 13", rd_data); end
        next_cycle();
    endtask

    task automatic test_raw();
        dma_req = 1'b1; dma_last = 1'b1; dma_addr = AW'(5); dma_data = PX_W'(8'hAA);
        @(negedge clk);
        n_cmp++; if (dma_gnt !== 1'b1) begin n_err++; $display("FAIL raw_dma_gnt: got %0b want 1", dma_gnt); end
        next_cycle();
        drive_idle(); rd_req = 1'b1; rd_addr = AW'(5);
        @(negedge clk);
        n_cmp++; if (rd_gnt !== 1'b1) begin n_err++; $display("FAIL raw_rd_gnt: got %0b want 1", rd_gnt); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL raw_valid_after_write: got %0b want 0", rd_valid); end
        next_cycle();
        rd_req = 1'b0;
        @(negedge clk);
        n_cmp++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL raw_rd_valid: got %0b want 1", rd_valid); end
        n_cmp++; if (rd_data !== PX_W'(8'hAA)) begin n_err++; $display("FAIL raw_rd_data: got %0h want aa", rd_data); end
        next_cycle();
    endtask

    task automatic test_quota();
        int grants = 0;
        bit got_dma = 1'b0;
        rd_req = 1'b1; dma_req = 1'b0; dma_last = 1'b1;
        dma_addr = AW'(7); dma_data = PX_W'(8'h77);
        for (int c = 0; c < 40 && !got_dma; c++) begin
            rd_addr = AW'($urandom_range(0, FMI_N_ELEM - 1));
            @(negedge clk);
            if (rd_gnt === 1'b1) grants++;
            if (dma_gnt === 1'b1) got_dma = 1'b1;
            n_cmp++; if ((rd_gnt & dma_gnt) !== 1'b0) begin n_err++; $display("FAIL quota_exclusive: rd_gnt %0b dma_gnt %0b want not both", rd_gnt, dma_gnt); end
            next_cycle();
            if (grants >= 3) dma_req = 1'b1;
        end
        n_cmp++; if (got_dma !== 1'b1) begin n_err++; $display("FAIL quota_dma_gnt_seen: got %0b want 1 within 40 cycles", got_dma); end
        n_cmp++; if (grants !== RD_QUOTA) begin n_err++; $display("FAIL quota_read_grants: got %0d want %0d", grants, RD_QUOTA); end
        drive_idle();
        next_cycle();
    endtask

    task automatic test_saturate();
        int g = 0;
        int v = 0;
        dma_req = 1'b0;
        for (int c = 0; c < 21; c++) begin
            rd_req   = (c < 20);
            rd_addr  = AW'($urandom_range(0, FMI_N_ELEM - 1));
            dma_last = 1'($urandom_range(0, 1));  // no dma_req: must be ignored
            @(negedge clk);
            if (rd_gnt === 1'b1) g++;
            if (rd_valid === 1'b1) v++;
            if (c == 19) begin
                n_cmp++; if (dbg_rd_cnt !== CW'(RD_QUOTA)) begin n_err++; $display("FAIL sat_rd_cnt: got %0d want %0d", dbg_rd_cnt, RD_QUOTA); end
            end
            next_cycle();
        end
        n_cmp++; if (g !== 20) begin n_err++; $display("FAIL sat_rd_gnt_count: got %0d want 20", g); end
        n_cmp++; if (v !== 20) begin n_err++; $display("FAIL sat_rd_valid_count: got %0d want 20", v); end
        drive_idle();
    endtask

    task automatic test_reset_mid_burst();
        // A read in flight is dropped by reset.
        rd_req = 1'b1; rd_addr = AW'(1);
        @(negedge clk);
        n_cmp++; if (rd_gnt !== 1'b1) begin n_err++; $display("FAIL pre_reset_rd_gnt: got %0b want 1", rd_gnt); end
        next_cycle();
        rd_req = 1'b0; reset = 1'b1;
        #1;
        n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_drops_rd_valid: got %0b want 0", rd_valid); end
        next_cycle();
        reset = 1'b0;
        next_cycle();
        // Burst interrupted on word 2.
        for (int i = 0; i < 2; i++) begin
            dma_req = 1'b1; dma_last = 1'b0; dma_addr = AW'(16 + i); dma_data = PX_W'(8'h40 + i);
            @(negedge clk);
            n_cmp++; if (dma_gnt !== 1'b1) begin n_err++; $display("FAIL mid_burst_dma_gnt[%0d]: got %0b want 1", i, dma_gnt); end
            next_cycle();
        end
        dma_addr = AW'(18); dma_data = PX_W'(8'h42); reset = 1'b1;
        #1;
        n_cmp++; if (dma_gnt !== 1'b0) begin n_err++; $display("FAIL mid_reset_dma_gnt: got %0b want 0", dma_gnt); end
        n_cmp++; if (rd_gnt !== 1'b0) begin n_err++; $display("FAIL mid_reset_rd_gnt: got %0b want 0", rd_gnt); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL mid_reset_rd_valid: got %0b want 0", rd_valid); end
        n_cmp++; if (ram_write !== 1'b0) begin n_err++; $display("FAIL mid_reset_ram_write: got %0b want 0", ram_write); end
        n_cmp++; if (ram_addr !== AW'(0)) begin n_err++; $display("FAIL mid_reset_ram_addr: got %0h want 0", ram_addr); end
        n_cmp++; if (ram_data !== PX_W'(0)) begin n_err++; $display("FAIL mid_reset_ram_data: got %0h want 0", ram_data); end
        n_cmp++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL mid_reset_state: got %0d want %0d", dbg_state, IDLE); end
        n_cmp++; if (dbg_rd_cnt !== CW'(0)) begin n_err++; $display("FAIL mid_reset_rd_cnt: got %0d want 0", dbg_rd_cnt); end
        next_cycle();
        reset = 1'b0; dma_addr = AW'(19); dma_data = PX_W'(8'h43); dma_last = 1'b1;
        @(negedge clk);
        n_cmp++; if (ram_write !== 1'b0) begin n_err++; $display("FAIL post_mid_reset_ram_write: got %0b want 0", ram_write); end
        n_cmp++; if (dma_gnt !== 1'b0) begin n_err++; $display("FAIL post_mid_reset_dma_gnt: got %0b want 0", dma_gnt); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL burst_aborted_state: got %0d want %0d", dbg_state, IDLE); end
        n_cmp++; if (dma_gnt !== 1'b1) begin n_err++; $display("FAIL after_abort_dma_gnt: got %0b want 1", dma_gnt); end
        next_cycle();
        drive_idle();
        next_cycle();
    endtask

    // Randomized traffic against a transaction-level model: who may own the
    // port follows from "burst in progress", "length of current read run"
    // and the quota rule; data follows from a reference memory.
    task automatic test_random();
        bit            m_blocked;
        bit            m_burst;
        int            m_run;
        logic [AW-1:0] m_last_addr;
        bit            e_dma, e_rd, e_valid;
        logic [AW-1:0] e_addr;
        logic [PX_W:0] ent;

        for (int a = 0; a < FMI_N_ELEM; a++) ref_known[a] = 1'b0;
        exp_q.delete();
        drive_idle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        m_blocked = 1'b1; m_burst = 1'b0; m_run = 0; m_last_addr = '0;

        for (int c = 0; c < 400; c++) begin
            dma_req  = ($urandom_range(0, 9) < 4);
            dma_last = ($urandom_range(0, 3) == 0);
            dma_addr = AW'($urandom_range(0, 7));
            dma_data = PX_W'($urandom);
            rd_req   = ($urandom_range(0, 9) < 6);
            rd_addr  = AW'($urandom_range(0, 7));

            e_dma = 1'b0; e_rd = 1'b0;
            if (m_blocked) begin
                e_dma = 1'b0;
            end else if (m_burst) begin
                e_dma = dma_req;
            end else if (m_run > 0) begin
                e_rd = rd_req && !((m_run >= RD_QUOTA) && dma_req);
            end else if (dma_req) begin
                e_dma = 1'b1;
            end else begin
                e_rd = rd_req;
            end
            e_addr  = e_dma ? dma_addr : (e_rd ? rd_addr : m_last_addr);
            e_valid = (exp_q.size() != 0);

            @(negedge clk);
            n_cmp++; if (dma_gnt !== e_dma) begin n_err++; $display("FAIL rand_dma_gnt @%0d: got %0b want %0b", c, dma_gnt, e_dma); end
            n_cmp++; if (rd_gnt !== e_rd) begin n_err++; $display("FAIL rand_rd_gnt @%0d: got %0b want %0b", c, rd_gnt, e_rd); end
            n_cmp++; if (ram_write !== e_dma) begin n_err++; $display("FAIL rand_ram_write @%0d: got %0b want %0b", c, ram_write, e_dma); end
            n_cmp++; if (ram_addr !== e_addr) begin n_err++; $display("FAIL rand_ram_addr @%0d: got %0h want %0h", c, ram_addr, e_addr); end
            if (e_dma) begin
                n_cmp++; if (ram_data !== dma_data) begin n_err++; $display("FAIL rand_ram_data @%0d: got %0h want %0h", c, ram_data, dma_data); end
            end
            n_cmp++; if (rd_valid !== e_valid) begin n_err++; $display("FAIL rand_rd_valid @%0d: got %0b want %0b", c, rd_valid, e_valid); end
            if (e_valid) begin
                ent = exp_q.pop_front();
                if (ent[PX_W]) begin
                    n_cmp++; if (rd_data !== ent[PX_W-1:0]) begin n_err++; $display("FAIL rand_rd_data @%0d: got %0h want %0h", c, rd_data, ent[PX_W-1:0]); end
                end
            end

            // Advance the model by one clock.
            if (e_dma) begin
                ref_mem[dma_addr]   = dma_data;
                ref_known[dma_addr] = 1'b1;
            end
            if (e_rd) exp_q.push_back({ref_known[rd_addr], ref_mem[rd_addr]});
            if (!m_blocked) begin
                if (m_burst) begin
                    if (dma_req && dma_last) m_burst = 1'b0;
                end else if (m_run > 0) begin
                    m_run = e_rd ? ((m_run < RD_QUOTA) ? m_run + 1 : RD_QUOTA) : 0;
                end else if (e_dma) begin
                    m_burst = !dma_last;
                end else if (e_rd) begin
                    m_run = 1;
                end
            end
            m_last_addr = e_addr;
            m_blocked   = 1'b0;
            next_cycle();
        end
        drive_idle();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- sequence and report ----------------
    initial begin
        reset = 1'b1;
        drive_idle();
        dma_addr = '0; dma_data = '0; rd_addr = '0;
        test_reset();
        test_burst();
        test_raw();
        test_quota();
        test_saturate();
        test_reset_mid_burst();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_fmi_ram_arbiter
